fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/next_pc_calc.sv | 44 ++++
 rtl/fetch_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the reset fetch address.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-cache request/response bundle between the fetch unit and the icache.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;

  modport master (
    output iREN,
    output iaddr,
    input  ihit,
    input  iload
  );

  modport slave (
    input  iREN,
    input  iaddr,
    output ihit,
    output iload
  );

endinterface

// File: rtl/next_pc_calc.sv
// Purely combinational next-pc selection: Halt > JR > Jmp > taken branch > sequential.
module next_pc_calc
  import cpu_types_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  word_t       pc,
  input  logic        Jmp,
  input  logic        JR,
  input  logic        branch,
  input  logic        bne,
  input  logic        Halt,
  input  logic        Zero,
  input  logic [25:0] imm26,
  input  logic [15:0] imm16,
  input  word_t       jr_addr,
  output word_t       next_pc
);

  word_t seq_pc;
  word_t br_target;
  word_t jmp_target;
  logic  br_taken;

  assign seq_pc     = pc + 32'(PC_STEP);
  // Word offset: sign-extend and scale by 4 in one concatenation.
  assign br_target  = seq_pc + {{14{imm16[15]}}, imm16, 2'b00};
  assign jmp_target = {seq_pc[31:28], imm26, 2'b00};
  assign br_taken   = branch & (Zero ^ bne);

  always_comb begin
    next_pc = seq_pc;
    if (Halt) begin
      next_pc = pc;
    end else if (JR) begin
      next_pc = jr_addr;
    end else if (Jmp) begin
      next_pc = jmp_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-issue fetch FSM: request a word, hold it until downstream accepts, then redirect pc.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = PC_INIT_DEFAULT,
  parameter int unsigned PC_STEP = 4
) (
  input  logic               CLK,
  input  logic               RST,
  fetch_unit_if.master       ibus,
  input  logic               stall,
  input  logic               Jmp,
  input  logic               JR,
  input  logic               branch,
  input  logic               bne,
  input  logic               Halt,
  input  logic               Zero,
  input  logic [25:0]        imm26,
  input  logic [15:0]        imm16,
  input  word_t              jr_addr,
  output word_t              Instr,
  output logic               instr_valid,
  output word_t              pc,
  output word_t              npc,
  output logic               halted
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  logic         valid_q, valid_d;
  word_t        target_pc;

  next_pc_calc #(
    .PC_STEP (PC_STEP)
  ) u_next_pc_calc (
    .pc      (pc_q),
    .Jmp     (Jmp),
    .JR      (JR),
    .branch  (branch),
    .bne     (bne),
    .Halt    (Halt),
    .Zero    (Zero),
    .imm26   (imm26),
    .imm16   (imm16),
    .jr_addr (jr_addr),
    .next_pc (target_pc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      FETCH: begin
        if (ibus.ihit) begin
          instr_d = ibus.iload;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Control inputs only matter on the cycle the held instruction retires.
        if (!stall) begin
          valid_d = 1'b0;
          if (Halt) begin
            state_d = HALTED;
          end else begin
            pc_d    = target_pc;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs below depend on registered state only.
  assign ibus.iREN   = (state_q == FETCH);
  assign ibus.iaddr  = pc_q;
  assign halted      = (state_q == HALTED);
  assign Instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign npc         = pc_q + 32'(PC_STEP);

endmodule
